reg_file: RTL and testbench



---
 rtl/reg_file.sv | 52 +++++
 tb/tb_reg_file.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Integer register file: 32 x 32-bit, two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wEn,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] write_sel,
   input  logic [ADDR_WIDTH-1:0] read_sel1,
   input  logic [ADDR_WIDTH-1:0] read_sel2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Writes to x0 are dropped here so the stored x0 never changes after reset.
   logic write_ok;
   assign write_ok = wEn && (write_sel != '0);

   // NOTE: this array is deliberately built from resettable flops rather than RAM,
   // because architectural state must clear on reset; do not copy this pattern for plain memories.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[write_sel] <= write_data;
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   // Forward the in-flight write so a reader sees write-before-read within the cycle.
   logic bypass1;
   logic bypass2;
   assign bypass1 = write_ok && !reset && (write_sel == read_sel1);
   assign bypass2 = write_ok && !reset && (write_sel == read_sel2);

   assign read_data1 = (read_sel1 == '0) ? '0 : (bypass1 ? write_data : regs[read_sel1]);
   assign read_data2 = (read_sel2 == '0) ? '0 : (bypass2 ? write_data : regs[read_sel2]);
`else
   assign read_data1 = (read_sel1 == '0) ? '0 : regs[read_sel1];
   assign read_data2 = (read_sel2 == '0) ? '0 : regs[read_sel2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; covers reset, writes, x0, wEn gating, same-cycle hazard and reset priority.
module tb_reg_file;

   logic        clock;
   logic        reset;
   logic        wEn;
   logic [31:0] write_data;
   logic [4:0]  write_sel;
   logic [4:0]  read_sel1;
   logic [4:0]  read_sel2;
   logic [31:0] read_data1;
   logic [31:0] read_data2;

   int total;
   int bad;

   reg_file dut (
      .clock      (clock),
      .reset      (reset),
      .wEn        (wEn),
      .write_data (write_data),
      .write_sel  (write_sel),
      .read_sel1  (read_sel1),
      .read_sel2  (read_sel2),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change on the falling edge; one write lands on the following rising edge.
   task automatic do_write(input logic [4:0] sel, input logic [31:0] data);
      @(negedge clock);
      wEn        = 1'b1;
      write_sel  = sel;
      write_data = data;
      @(negedge clock);
      wEn        = 1'b0;
   endtask

   task automatic sweep_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         read_sel1 = 5'(i);
         read_sel2 = 5'(31 - i);
         #1;
         total++;
         if (read_data1 !== 32'h0) begin
            bad++;
            $display("FAIL %s port1 x%0d: got %h want %h", tag, i, read_data1, 32'h0);
         end
         total++;
         if (read_data2 !== 32'h0) begin
            bad++;
            $display("FAIL %s port2 x%0d: got %h want %h", tag, 31 - i, read_data2, 32'h0);
         end
      end
   endtask

   task automatic test_reset;
      reset      = 1'b1;
      wEn        = 1'b0;
      write_sel  = 5'd0;
      write_data = 32'h0;
      read_sel1  = 5'd0;
      read_sel2  = 5'd0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      sweep_zero("reset_clear");
   endtask

   task automatic test_single_write;
      do_write(5'd2, 32'hDEADBEEF);
      read_sel1 = 5'd2;
      read_sel2 = 5'd2;
      #1;
      total++;
      if (read_data1 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL single_write port1: got %h want %h", read_data1, 32'hDEADBEEF);
      end
      total++;
      if (read_data2 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL single_write port2: got %h want %h", read_data2, 32'hDEADBEEF);
      end
      read_sel1 = 5'd1;
      read_sel2 = 5'd3;
      #1;
      total++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
         bad++;
         $display("FAIL single_write neighbours: got %h/%h want 0/0", read_data1, read_data2);
      end
   endtask

   task automatic test_x0;
      do_write(5'd0, 32'hFFFFFFFF);
      read_sel1 = 5'd0;
      read_sel2 = 5'd0;
      #1;
      total++;
      if (read_data1 !== 32'h0) begin
         bad++;
         $display("FAIL x0_write port1: got %h want %h", read_data1, 32'h0);
      end
      total++;
      if (read_data2 !== 32'h0) begin
         bad++;
         $display("FAIL x0_write port2: got %h want %h", read_data2, 32'h0);
      end
   endtask

   task automatic test_wen_gating;
      @(negedge clock);
      wEn        = 1'b0;
      write_sel  = 5'd5;
      write_data = 32'h12345678;
      repeat (3) @(negedge clock);
      write_data = 'x;
      repeat (3) @(negedge clock);
      write_data = 32'h0;
      read_sel1  = 5'd5;
      read_sel2  = 5'd2;
      #1;
      total++;
      if (read_data1 !== 32'h0) begin
         bad++;
         $display("FAIL wen_gating x5: got %h want %h", read_data1, 32'h0);
      end
      total++;
      if (read_data2 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL wen_gating x2: got %h want %h", read_data2, 32'hDEADBEEF);
      end
   endtask

   task automatic test_same_cycle;
      logic [31:0] exp_before;
`ifdef REGFILE_WRITE_BYPASS_EN
      exp_before = 32'h5A5A5A5A;
`else
      exp_before = 32'hA5A5A5A5;
`endif
      do_write(5'd7, 32'hA5A5A5A5);
      @(negedge clock);
      wEn        = 1'b1;
      write_sel  = 5'd7;
      write_data = 32'h5A5A5A5A;
      read_sel1  = 5'd7;
      read_sel2  = 5'd7;
      #1;
      total++;
      if (read_data1 !== exp_before) begin
         bad++;
         $display("FAIL hazard_before port1: got %h want %h", read_data1, exp_before);
      end
      total++;
      if (read_data2 !== exp_before) begin
         bad++;
         $display("FAIL hazard_before port2: got %h want %h", read_data2, exp_before);
      end
      @(posedge clock);
      #1;
      total++;
      if (read_data1 !== 32'h5A5A5A5A) begin
         bad++;
         $display("FAIL hazard_after port1: got %h want %h", read_data1, 32'h5A5A5A5A);
      end
      @(negedge clock);
      wEn = 1'b0;
      #1;
      total++;
      if (read_data2 !== 32'h5A5A5A5A) begin
         bad++;
         $display("FAIL hazard_after port2: got %h want %h", read_data2, 32'h5A5A5A5A);
      end
   endtask

   task automatic test_reset_priority;
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i));
      end
      for (int i = 1; i < 32; i++) begin
         read_sel1 = 5'(i);
         read_sel2 = 5'(32 - i);
         #1;
         total++;
         if (read_data1 !== 32'(i) || read_data2 !== 32'(32 - i)) begin
            bad++;
            $display("FAIL fill x%0d/x%0d: got %h/%h want %h/%h",
                     i, 32 - i, read_data1, read_data2, 32'(i), 32'(32 - i));
         end
      end
      @(negedge clock);
      reset      = 1'b1;
      wEn        = 1'b1;
      write_sel  = 5'd3;
      write_data = 32'hCAFEF00D;
      read_sel1  = 5'd3;
      #1;
      // No forwarding while reset is high, in either build.
      total++;
      if (read_data1 !== 32'h3) begin
         bad++;
         $display("FAIL reset_no_bypass x3: got %h want %h", read_data1, 32'h3);
      end
      @(negedge clock);
      reset = 1'b0;
      wEn   = 1'b0;
      sweep_zero("reset_priority");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset;
      test_single_write;
      test_x0;
      test_wen_gating;
      test_same_cycle;
      test_reset_priority;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
